// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit for MUL, MULHU, DIVU and REMU.
// Shift-add multiply and restoring divide share one {hi, lo} register pair.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wb_en
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [5:0]      cnt;
  logic [1:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  logic [XLEN-1:0] hi_nx;
  logic [XLEN-1:0] lo_nx;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            ge;

  assign busy = (state != IDLE);

  // Remainder never exceeds the divisor, so the difference fits in XLEN bits.
  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : '0);
    rem_sh = {hi, lo[XLEN-1]};
    ge     = (rem_sh >= {1'b0, b_q});
    diff   = rem_sh[XLEN-1:0] - b_q;
    hi_nx  = hi;
    lo_nx  = lo;
    unique case (1'b1)
      op_q[1]: begin
        hi_nx = ge ? diff : rem_sh[XLEN-1:0];
        lo_nx = {lo[XLEN-2:0], ge};
      end
      default: begin
        hi_nx = sum[XLEN:1];
        lo_nx = {sum[0], lo[XLEN-1:1]};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rd_q   <= '0;
      hi     <= '0;
      lo     <= '0;
      result <= '0;
      rd_out <= '0;
      done   <= 1'b0;
      wb_en  <= 1'b0;
    end else begin
      done  <= 1'b0;
      wb_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            op_q  <= op;
            a_q   <= rs1_val;
            b_q   <= rs2_val;
            rd_q  <= rd_in;
            cnt   <= '0;
            hi    <= '0;
            lo    <= op[1] ? rs1_val : rs2_val;
          end
        end
        RUN: begin
          if (cnt == 6'd32) begin
            state  <= DONE;
            result <= op_q[0] ? hi : lo;
            rd_out <= rd_q;
            done   <= 1'b1;
            wb_en  <= (rd_q != 5'd0);
          end else begin
            cnt <= cnt + 6'd1;
            hi  <= hi_nx;
            lo  <= lo_nx;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: reference results are queued at
// issue and compared when done pulses.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        wb_en;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];

  mul_div_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_in   (rd_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rd_out  (rd_out),
    .wb_en   (wb_en)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input bit disturb);
    int   n;
    int   extra;
    bit   seen;
    exp_t e;
    e.res = model(o, a, b);
    e.rd  = rd;
    sb.push_back(e);
    @(negedge clk);
    op      = o;
    rs1_val = a;
    rs2_val = b;
    rd_in   = rd;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    n    = 0;
    seen = 0;
    while (n < 40 && !seen) begin
      if (disturb && n == 5) begin
        start   = 1'b1;
        rs1_val = ~a;
        rs2_val = b + 32'd1;
        op      = ~o;
        rd_in   = rd + 5'd1;
      end
      if (disturb && n == 7) start = 1'b0;
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1;
    end
    check_eq("latency", n, 33);
    if (sb.size() != 0) e = sb.pop_front();
    if (seen) begin
      check_eq("result", result, e.res);
      check_eq("rd_out", rd_out, e.rd);
      check_eq("wb_en", wb_en, (e.rd != 0));
    end
    @(posedge clk);
    #1;
    check_eq("done_one_cycle", done, 0);
    check_eq("wb_en_one_cycle", wb_en, 0);
    check_eq("busy_cleared", busy, 0);
    check_eq("result_hold", result, e.res);
    if (disturb) begin
      extra = 0;
      repeat (36) begin
        @(posedge clk);
        #1;
        if (done) extra++;
      end
      check_eq("no_extra_done", extra, 0);
    end
  endtask

  initial begin
    int dc;
    logic [31:0] ra;
    logic [31:0] rb;
    rst     = 1'b0;
    start   = 1'b0;
    op      = 2'd0;
    rs1_val = '0;
    rs2_val = '0;
    rd_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_rd_out", rd_out, 0);
    check_eq("rst_wb_en", wb_en, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_eq("idle_busy", busy, 0);
      check_eq("idle_done", done, 0);
      check_eq("idle_result", result, 0);
    end

    run_op(2'd0, 32'd7, 32'd6, 5'd3, 0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0);
    run_op(2'd2, 32'd100, 32'd7, 5'd10, 0);
    run_op(2'd3, 32'd100, 32'd7, 5'd11, 0);
    run_op(2'd2, 32'h8000_0000, 32'd1, 5'd12, 0);
    run_op(2'd2, 32'd1234, 32'd0, 5'd13, 0);
    run_op(2'd3, 32'd1234, 32'd0, 5'd14, 0);
    run_op(2'd0, 32'd21, 32'd2, 5'd15, 1);
    run_op(2'd0, 32'd9, 32'd9, 5'd0, 0);
    run_op(2'd3, 32'd17, 32'd5, 5'd5, 0);
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom >> (i * 3);
      run_op(2'(i % 4), ra, rb, 5'($urandom_range(0, 31)), 0);
    end

    run_op(2'd0, 32'd5, 32'd5, 5'd6, 0);
    @(negedge clk);
    op      = 2'd2;
    rs1_val = 32'd1000;
    rs2_val = 32'd3;
    rd_in   = 5'd9;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_result", result, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_rd_out", rd_out, 0);
    @(negedge clk);
    rst = 1'b1;
    dc  = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dc++;
    end
    check_eq("abort_no_done", dc, 0);
    run_op(2'd0, 32'd3, 32'd3, 5'd7, 0);
    check_eq("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
